// File: rtl/cpu_mem_responder.sv
// Magic-memory responder for the CPU imem/dmem request-response ports.
// One shared word array; each port runs its own fixed-latency IDLE/WAIT/RESP handshake.
module cpu_mem_responder #(
    parameter int unsigned DEPTH_WORDS = 4096,
    parameter int unsigned I_LATENCY   = 1,
    parameter int unsigned D_LATENCY   = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] imem_address,
    input  logic        imem_read,
    output logic [31:0] imem_rdata,
    output logic        imem_resp,
    input  logic [31:0] dmem_address,
    input  logic        dmem_read,
    input  logic        dmem_write,
    input  logic [3:0]  dmem_wmask,
    input  logic [31:0] dmem_wdata,
    output logic [31:0] dmem_rdata,
    output logic        dmem_resp,
    output logic        proto_err
);

    localparam int unsigned IDX_W   = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    localparam int unsigned I_CNT_W = $clog2(I_LATENCY + 1);
    localparam int unsigned D_CNT_W = $clog2(D_LATENCY + 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_e;

    // Word index of a byte address; wraps modulo the array depth.
    function automatic logic [IDX_W-1:0] word_idx(input logic [29:0] waddr);
        return IDX_W'(32'(waddr) % DEPTH_WORDS);
    endfunction

    logic [31:0] mem [DEPTH_WORDS];

    state_e               i_state_q, i_state_d;
    logic [I_CNT_W-1:0]   i_cnt_q, i_cnt_d;
    logic [IDX_W-1:0]     i_idx_q, i_idx_d;

    state_e               d_state_q, d_state_d;
    logic [D_CNT_W-1:0]   d_cnt_q, d_cnt_d;
    logic [IDX_W-1:0]     d_idx_q, d_idx_d;
    logic                 d_we_q, d_we_d;
    logic [3:0]           d_wmask_q, d_wmask_d;
    logic [31:0]          d_wdata_q, d_wdata_d;

    logic                 imem_resp_q, imem_resp_d;
    logic [31:0]          imem_rdata_q, imem_rdata_d;
    logic                 dmem_resp_q, dmem_resp_d;
    logic [31:0]          dmem_rdata_q, dmem_rdata_d;
    logic                 proto_err_q, proto_err_d;
    logic                 mem_we_c;

    logic                 unused_addr_lsb;
    assign unused_addr_lsb = ^{imem_address[1:0], dmem_address[1:0]};

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            i_state_q    <= ST_IDLE;
            i_cnt_q      <= '0;
            i_idx_q      <= '0;
            d_state_q    <= ST_IDLE;
            d_cnt_q      <= '0;
            d_idx_q      <= '0;
            d_we_q       <= 1'b0;
            d_wmask_q    <= '0;
            d_wdata_q    <= '0;
            imem_resp_q  <= 1'b0;
            imem_rdata_q <= '0;
            dmem_resp_q  <= 1'b0;
            dmem_rdata_q <= '0;
            proto_err_q  <= 1'b0;
        end else begin
            i_state_q    <= i_state_d;
            i_cnt_q      <= i_cnt_d;
            i_idx_q      <= i_idx_d;
            d_state_q    <= d_state_d;
            d_cnt_q      <= d_cnt_d;
            d_idx_q      <= d_idx_d;
            d_we_q       <= d_we_d;
            d_wmask_q    <= d_wmask_d;
            d_wdata_q    <= d_wdata_d;
            imem_resp_q  <= imem_resp_d;
            imem_rdata_q <= imem_rdata_d;
            dmem_resp_q  <= dmem_resp_d;
            dmem_rdata_q <= dmem_rdata_d;
            proto_err_q  <= proto_err_d;
        end
    end

    // Next-state logic for both ports; request fields are captured on accept
    always_comb begin
        i_state_d = i_state_q;
        i_cnt_d   = i_cnt_q;
        i_idx_d   = i_idx_q;
        case (i_state_q)
            ST_IDLE: begin
                if (imem_read) begin
                    i_idx_d   = word_idx(imem_address[31:2]);
                    i_cnt_d   = I_CNT_W'(I_LATENCY - 1);
                    i_state_d = (I_LATENCY == 1) ? ST_RESP : ST_WAIT;
                end
            end
            ST_WAIT: begin
                i_cnt_d = i_cnt_q - I_CNT_W'(1);
                if (i_cnt_q <= I_CNT_W'(1)) begin
                    i_state_d = ST_RESP;
                end
            end
            ST_RESP: i_state_d = ST_IDLE;
            default: i_state_d = ST_IDLE;
        endcase

        d_state_d = d_state_q;
        d_cnt_d   = d_cnt_q;
        d_idx_d   = d_idx_q;
        d_we_d    = d_we_q;
        d_wmask_d = d_wmask_q;
        d_wdata_d = d_wdata_q;
        case (d_state_q)
            ST_IDLE: begin
                if (dmem_read || dmem_write) begin
                    d_idx_d   = word_idx(dmem_address[31:2]);
                    d_we_d    = dmem_write;
                    d_wmask_d = dmem_wmask;
                    d_wdata_d = dmem_wdata;
                    d_cnt_d   = D_CNT_W'(D_LATENCY - 1);
                    d_state_d = (D_LATENCY == 1) ? ST_RESP : ST_WAIT;
                end
            end
            ST_WAIT: begin
                d_cnt_d = d_cnt_q - D_CNT_W'(1);
                if (d_cnt_q <= D_CNT_W'(1)) begin
                    d_state_d = ST_RESP;
                end
            end
            ST_RESP: d_state_d = ST_IDLE;
            default: d_state_d = ST_IDLE;
        endcase
    end

    // Output logic: responses, read data and write strobe all act on the edge entering RESP
    always_comb begin
        imem_resp_d  = (i_state_d == ST_RESP);
        imem_rdata_d = imem_resp_d ? mem[i_idx_d] : imem_rdata_q;
        dmem_resp_d  = (d_state_d == ST_RESP);
        dmem_rdata_d = (dmem_resp_d && !d_we_d) ? mem[d_idx_d] : dmem_rdata_q;
        mem_we_c     = dmem_resp_d && d_we_d && !rst;
        proto_err_d  = proto_err_q
                     || ((d_state_q == ST_IDLE) && dmem_read && dmem_write);
    end

    // Array is never reset; same-edge readers above see the pre-write contents
    always_ff @(posedge clk) begin
        if (mem_we_c) begin
            for (int b = 0; b < 4; b++) begin
                if (d_wmask_d[b]) begin
                    mem[d_idx_d][8*b +: 8] <= d_wdata_d[8*b +: 8];
                end
            end
        end
    end

    assign imem_resp  = imem_resp_q;
    assign imem_rdata = imem_rdata_q;
    assign dmem_resp  = dmem_resp_q;
    assign dmem_rdata = dmem_rdata_q;
    assign proto_err  = proto_err_q;

endmodule

// File: tb/tb_cpu_mem_responder.sv
// Bench for cpu_mem_responder: directed corner cases plus a random mix of
// imem/dmem transactions checked against a word-array reference model.
module tb_cpu_mem_responder;

    localparam int unsigned DEPTH = 4096;
    localparam int unsigned I_LAT = 1;
    localparam int unsigned D_LAT = 3;
    localparam int          TIMEOUT = 20;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] imem_address;
    logic        imem_read;
    logic [31:0] imem_rdata;
    logic        imem_resp;
    logic [31:0] dmem_address;
    logic        dmem_read;
    logic        dmem_write;
    logic [3:0]  dmem_wmask;
    logic [31:0] dmem_wdata;
    logic [31:0] dmem_rdata;
    logic        dmem_resp;
    logic        proto_err;

    always #5 clk = ~clk;

    cpu_mem_responder #(
        .DEPTH_WORDS(DEPTH),
        .I_LATENCY  (I_LAT),
        .D_LATENCY  (D_LAT)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .imem_address(imem_address),
        .imem_read   (imem_read),
        .imem_rdata  (imem_rdata),
        .imem_resp   (imem_resp),
        .dmem_address(dmem_address),
        .dmem_read   (dmem_read),
        .dmem_write  (dmem_write),
        .dmem_wmask  (dmem_wmask),
        .dmem_wdata  (dmem_wdata),
        .dmem_rdata  (dmem_rdata),
        .dmem_resp   (dmem_resp),
        .proto_err   (proto_err)
    );

    int          checks = 0;
    int          errors = 0;
    logic [31:0] ref_mem [int];
    logic [31:0] ref_drdata;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic int widx(input logic [31:0] a);
        return int'((a >> 2) % DEPTH);
    endfunction

    function automatic logic [31:0] merge_bytes(input logic [31:0] old, input logic [31:0] data,
                                                input logic [3:0] m);
        logic [31:0] keep;
        keep = {{8{~m[3]}}, {8{~m[2]}}, {8{~m[1]}}, {8{~m[0]}}};
        return (old & keep) | (data & ~keep);
    endfunction

    task automatic dmem_op(input logic [31:0] addr, input logic rd, input logic wr,
                           input logic [3:0] mask, input logic [31:0] wdata, input bit perturb,
                           output logic [31:0] rdata, output int lat);
        @(negedge clk);
        dmem_address = addr;
        dmem_read    = rd;
        dmem_write   = wr;
        dmem_wmask   = mask;
        dmem_wdata   = wdata;
        @(posedge clk);
        lat = -1;
        for (int k = 1; k <= TIMEOUT; k++) begin
            @(negedge clk);
            if (dmem_resp) begin
                lat = k;
                break;
            end
            if (perturb) begin
                dmem_read    = 1'b0;
                dmem_write   = 1'b0;
                dmem_address = $urandom;
                dmem_wdata   = $urandom;
                dmem_wmask   = 4'($urandom);
            end
        end
        rdata      = dmem_rdata;
        dmem_read  = 1'b0;
        dmem_write = 1'b0;
        if (wr) begin
            chk("d_wr_rdata_hold", dmem_rdata, ref_drdata);
            ref_mem[widx(addr)] = merge_bytes(ref_mem[widx(addr)], wdata, mask);
        end else begin
            ref_drdata = ref_mem[widx(addr)];
        end
        @(negedge clk);
        chk("d_resp_one_cycle", 32'(dmem_resp), 32'd0);
    endtask

    task automatic imem_op(input logic [31:0] addr, input bit perturb,
                           output logic [31:0] rdata, output int lat);
        @(negedge clk);
        imem_address = addr;
        imem_read    = 1'b1;
        @(posedge clk);
        lat = -1;
        for (int k = 1; k <= TIMEOUT; k++) begin
            @(negedge clk);
            if (imem_resp) begin
                lat = k;
                break;
            end
            if (perturb) begin
                imem_read    = 1'b0;
                imem_address = $urandom;
            end
        end
        rdata     = imem_rdata;
        imem_read = 1'b0;
        @(negedge clk);
        chk("i_resp_one_cycle", 32'(imem_resp), 32'd0);
    endtask

    initial begin
        #2ms;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] rd;
        logic [31:0] exp;
        logic [31:0] old;
        logic [31:0] a;
        int          lat;
        int          idx;
        int          pulses;
        int          idx_list[$];

        rst = 1'b1;
        imem_address = '0; imem_read = 1'b0;
        dmem_address = '0; dmem_read = 1'b0; dmem_write = 1'b0;
        dmem_wmask = '0; dmem_wdata = '0;
        ref_drdata = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_imem_resp",  32'(imem_resp), 32'd0);
        chk("rst_dmem_resp",  32'(dmem_resp), 32'd0);
        chk("rst_imem_rdata", imem_rdata, 32'd0);
        chk("rst_dmem_rdata", dmem_rdata, 32'd0);
        chk("rst_proto_err",  32'(proto_err), 32'd0);
        rst = 1'b0;

        // Initialise every word the bench will read
        for (int i = 0; i < 16; i++) idx_list.push_back(i);
        for (int i = int'(DEPTH) - 8; i < int'(DEPTH); i++) idx_list.push_back(i);
        idx_list.push_back(24);  idx_list.push_back(64);  idx_list.push_back(128);
        idx_list.push_back(192); idx_list.push_back(256);
        foreach (idx_list[i]) begin
            ref_mem[idx_list[i]] = '0;
            dmem_op(32'(idx_list[i]) << 2, 1'b0, 1'b1, 4'hF, $urandom, 1'b0, rd, lat);
        end
        chk("d_wr_lat", 32'(lat), 32'(D_LAT));

        imem_op(32'h60, 1'b0, rd, lat);
        chk("i_lat", 32'(lat), 32'(I_LAT));
        chk("i_data_0x60", rd, ref_mem[24]);

        dmem_op(32'h100, 1'b0, 1'b1, 4'hF, 32'h11223344, 1'b0, rd, lat);
        chk("bw_full_lat", 32'(lat), 32'(D_LAT));
        dmem_op(32'h100, 1'b0, 1'b1, 4'b0110, 32'hAABBCCDD, 1'b0, rd, lat);
        chk("bw_part_lat", 32'(lat), 32'(D_LAT));
        dmem_op(32'h100, 1'b1, 1'b0, 4'h0, 32'h0, 1'b0, rd, lat);
        chk("bw_rd_lat", 32'(lat), 32'(D_LAT));
        chk("bw_merge", rd, 32'h11BBCC44);

        dmem_op(32'h100, 1'b0, 1'b1, 4'h0, 32'hFFFFFFFF, 1'b0, rd, lat);
        chk("mask0_lat", 32'(lat), 32'(D_LAT));
        dmem_op(32'h100, 1'b1, 1'b0, 4'h0, 32'h0, 1'b0, rd, lat);
        chk("mask0_data", rd, 32'h11BBCC44);

        // Random mix with aliased addresses, random byte lanes and early request drop
        for (int n = 0; n < 300; n++) begin
            idx = idx_list[$urandom_range(0, idx_list.size() - 1)];
            a   = ($urandom & ~(32'(DEPTH) * 4 - 1)) | (32'(idx) << 2) | 32'($urandom_range(0, 3));
            case ($urandom_range(0, 2))
                0: begin
                    exp = ref_mem[idx];
                    imem_op(a, 1'($urandom_range(0, 1)), rd, lat);
                    chk("rnd_i_lat", 32'(lat), 32'(I_LAT));
                    chk("rnd_i_data", rd, exp);
                end
                1: begin
                    exp = ref_mem[idx];
                    dmem_op(a, 1'b1, 1'b0, 4'($urandom), $urandom, 1'($urandom_range(0, 1)), rd, lat);
                    chk("rnd_d_lat", 32'(lat), 32'(D_LAT));
                    chk("rnd_d_data", rd, exp);
                end
                default: begin
                    dmem_op(a, 1'b0, 1'b1, 4'($urandom), $urandom, 1'($urandom_range(0, 1)), rd, lat);
                    chk("rnd_w_lat", 32'(lat), 32'(D_LAT));
                end
            endcase
        end

        // imem read and dmem write to the same word reach RESP on one edge
        old = ref_mem[128];
        @(negedge clk);
        dmem_address = 32'h200; dmem_write = 1'b1; dmem_wmask = 4'hF; dmem_wdata = 32'hDEADBEEF;
        @(posedge clk);
        repeat (D_LAT - I_LAT) @(negedge clk);
        chk("cf_d_not_early", 32'(dmem_resp), 32'd0);
        imem_address = 32'h200; imem_read = 1'b1;
        repeat (I_LAT) @(negedge clk);
        chk("cf_i_resp", 32'(imem_resp), 32'd1);
        chk("cf_d_resp", 32'(dmem_resp), 32'd1);
        chk("cf_i_old", imem_rdata, old);
        imem_read = 1'b0; dmem_write = 1'b0;
        ref_mem[128] = 32'hDEADBEEF;
        @(negedge clk);
        chk("cf_resp_drop", 32'({imem_resp, dmem_resp}), 32'd0);
        imem_op(32'h200, 1'b0, rd, lat);
        chk("cf_new", rd, 32'hDEADBEEF);

        // Reset while a write is waiting aborts it
        old = ref_mem[192];
        @(negedge clk);
        dmem_address = 32'h300; dmem_write = 1'b1; dmem_wmask = 4'hF; dmem_wdata = ~old;
        @(posedge clk);
        @(negedge clk);
        chk("ro_wait", 32'(dmem_resp), 32'd0);
        rst = 1'b1; dmem_write = 1'b0;
        @(negedge clk);
        chk("ro_imem_resp",  32'(imem_resp), 32'd0);
        chk("ro_dmem_resp",  32'(dmem_resp), 32'd0);
        chk("ro_imem_rdata", imem_rdata, 32'd0);
        chk("ro_dmem_rdata", dmem_rdata, 32'd0);
        chk("ro_proto_err",  32'(proto_err), 32'd0);
        pulses = 0;
        for (int k = 0; k < int'(D_LAT) + 2; k++) begin
            @(negedge clk);
            if (k == 1) rst = 1'b0;
            if (dmem_resp) pulses++;
        end
        chk("ro_no_resp", 32'(pulses), 32'd0);
        ref_drdata = '0;
        dmem_op(32'h300, 1'b1, 1'b0, 4'h0, 32'h0, 1'b0, rd, lat);
        chk("ro_unchanged", rd, old);

        // Read and write together: performed as a write, sticky error flag
        chk("pe_clear", 32'(proto_err), 32'd0);
        dmem_op(32'h400, 1'b1, 1'b1, 4'hF, 32'hC0FFEE11, 1'b0, rd, lat);
        chk("pe_lat", 32'(lat), 32'(D_LAT));
        chk("pe_set", 32'(proto_err), 32'd1);
        dmem_op(32'h400, 1'b1, 1'b0, 4'h0, 32'h0, 1'b0, rd, lat);
        chk("pe_write_done", rd, 32'hC0FFEE11);
        imem_op(32'h0, 1'b0, rd, lat);
        chk("pe_sticky", 32'(proto_err), 32'd1);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("pe_rst_clear", 32'(proto_err), 32'd0);
        rst = 1'b0;
        @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
